// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the push/pop operation encoding used by the
// return-address stack.
package cpu_pkg;

    localparam int PC_W      = 19;
    localparam int RAS_DEPTH = 16;
    localparam int RAS_PTR_W = 4;

    // {push, pop} request pair decoded as one operation
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } ras_op_e;

endpackage

// File: rtl/lifo_regfile.sv
// Return-address storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owner tracks which entries are valid.
module lifo_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = PC_W,
    parameter int DEPTH  = RAS_DEPTH,
    parameter int PTR_W  = RAS_PTR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// LIFO return-address stack for CALL/RET with a zero-latency top-of-stack view,
// sticky overflow/underflow flags, a high-water mark and a synchronous flush.
module ret_addr_stack
    import cpu_pkg::*;
#(
    parameter int DATA_W = PC_W,
    parameter int DEPTH  = RAS_DEPTH,
    parameter int PTR_W  = RAS_PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    input  logic              err_clr,
    output logic [DATA_W-1:0] pop_data,
    output logic [PTR_W-1:0]  sp,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              overflow,
    output logic              underflow,
    output logic [PTR_W:0]    high_water
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W:0]    hw_q, hw_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic [PTR_W-1:0]  top_idx;
    logic [DATA_W-1:0] rdata;
    ras_op_e           op;

    assign stack_empty = (count_q == '0);
    assign stack_full  = (count_q == DEPTH_C);
    assign top_idx     = PTR_W'(count_q - ONE_C);
    assign op          = ras_op_e'({push, pop});

    always_comb begin
        count_d = count_q;
        hw_d    = hw_q;
        ovf_d   = err_clr ? 1'b0 : ovf_q;
        unf_d   = err_clr ? 1'b0 : unf_q;
        we      = 1'b0;
        waddr   = count_q[PTR_W-1:0];
        if (flush) begin
            count_d = '0;
            hw_d    = '0;
            ovf_d   = ovf_q;
            unf_d   = unf_q;
        end else begin
            unique case (op)
                OP_PUSH: begin
                    if (stack_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        we      = 1'b1;
                        count_d = count_q + ONE_C;
                    end
                end
                OP_POP: begin
                    if (stack_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        count_d = count_q - ONE_C;
                    end
                end
                OP_REPL: begin
                    // Replace on an empty stack degrades to a plain push but still
                    // records the missing pop.
                    we = 1'b1;
                    if (stack_empty) begin
                        waddr   = '0;
                        count_d = ONE_C;
                        unf_d   = 1'b1;
                    end else begin
                        waddr = top_idx;
                    end
                end
                default: ;
            endcase
            if (count_d > hw_q) begin
                hw_d = count_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            hw_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            hw_q    <= hw_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    lifo_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (push_data),
        .raddr (top_idx),
        .rdata (rdata)
    );

    assign pop_data   = stack_empty ? '0 : rdata;
    assign sp         = count_q[PTR_W-1:0];
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign high_water = hw_q;

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
LIFO return-address store that answers the push/pop requests issued by the subroutine call/return unit. The subroutine unit pushes PC+1 on CALL and pops on RET. This block holds the entries and presents the top entry combinationally so a RET can redirect the PC in the same cycle. It also reports the pointer and full/empty status, and adds sticky overflow/underflow error flags, a high-water mark, and a synchronous flush for program restart.

Parameters:
DATA_W, 19, return-address width (matches the PC width).
DEPTH, 16, number of entries; must be a power of two and at least 2.
PTR_W, 4, log2(DEPTH); width of sp.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-low reset.
push  in  1  write push_data on top this cycle.
push_data  in  DATA_W  return address to store.
pop  in  1  remove the top entry this cycle.
flush  in  1  synchronous clear of all entries.
err_clr  in  1  clears the sticky error flags.
pop_data  out  DATA_W  current top entry; combinational.
sp  out  PTR_W  index of the next free slot; equals count[PTR_W-1:0].
stack_empty  out  1  count == 0.
stack_full  out  1  count == DEPTH.
overflow  out  1  sticky; set by a push while full.
underflow  out  1  sticky; set by a pop while empty.
high_water  out  PTR_W+1  maximum count reached since reset or flush.

Behaviour:
- State:
  - count register, PTR_W+1 bits, range 0..DEPTH.
  - mem[DEPTH] of DATA_W bits.
  - overflow and underflow flags.
  - high_water register.
- Reset (reset=0, asynchronous): count=0, overflow=0, underflow=0, high_water=0.
  - mem contents are not cleared.
  - Outputs after reset: pop_data=0, sp=0, stack_empty=1, stack_full=0.
- pop_data = stack_empty ? 0 : mem[count-1].
  - Zero latency, so the caller can use it in the same cycle it asserts pop.
- All updates occur on the rising clk edge. Priority order: flush, then the push/pop cases.
- flush=1: count=0 and high_water=0. push and pop are ignored that cycle. Error flags are unchanged.
- push=1, pop=0:
  - If not full: mem[count]=push_data, count+1.
  - If full: no write, count holds, overflow=1.
- pop=1, push=0:
  - If not empty: count-1. The entry is not erased.
  - If empty: count holds, underflow=1.
- push=1, pop=1 (replace top):
  - If not empty: mem[count-1]=push_data, count unchanged. Valid when full.
  - If empty: acts as a push (mem[0]=push_data, count=1), and underflow=1.
- high_water: updated to next-count whenever next-count exceeds it. Never decreases except on flush or reset.
- err_clr=1: overflow=0 and underflow=0 next edge.
  - If an error event occurs in the same cycle, the set wins.
- sp wraps to 0 when count==DEPTH. Use stack_full to tell full from empty.
- Reset asserted mid-operation discards any in-flight push or pop immediately.
- No operation is ever partially applied. count changes by at most 1 per cycle.

Decomposition:
- Shared package (cpu_pkg):
  - PC_W=19, used as the DATA_W default.
  - RAS_DEPTH=16.
  - RAS_PTR_W=4.
- The storage array is a natural sub-module, lifo_regfile: one write port, one asynchronous read port at index count-1. Flags and counters stay in ret_addr_stack.

Test Plan:
1. Reset with reset=0 for 2 cycles, then release. Expect stack_empty=1, sp=0, pop_data=0, high_water=0, overflow=0, underflow=0.
2. Push 0x00010, 0x00020, 0x00030 on consecutive cycles. Expect sp=3 and pop_data=0x00030. Pop three times: pop_data is 0x00030, 0x00020, then 0x00010 during the pop cycles; afterwards stack_empty=1 and high_water=3.
3. Push 16 distinct values. Expect stack_full=1 and sp=0. A 17th push of 0x7FFFF leaves count=16 and pop_data equal to the 16th value, and sets overflow=1. err_clr clears overflow.
4. Pop while empty. Expect underflow=1, count=0, pop_data=0. Assert err_clr and pop together while empty: underflow stays 1.
5. With 2 entries (0x00100, 0x00200), assert push=1, pop=1, push_data=0x00ABC. Expect count=2 and pop_data=0x00ABC. Repeat while full: count stays 16 and no overflow.
6. Push 5 entries, then assert flush together with push. Expect count=0, stack_empty=1, high_water=0; sticky flags keep their prior values. Assert reset in the middle of a push burst: count is immediately 0.
